// File: rtl/router_pkg.sv
// Shared flit width, destination-field position and default router sizing.
package router_pkg;

    localparam int FLIT_DATA_WIDTH = 32;
    localparam int DEF_NUM_PORTS   = 5;
    localparam int DEF_NUM_VC      = 4;
    localparam int DST_FIELD_MSB   = FLIT_DATA_WIDTH - 1;

    typedef logic [FLIT_DATA_WIDTH-1:0] flit_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/router_top_vc_availability.sv
// Output-VC credit counters and per-cycle output-VC allocation.
module vc_availability
    import router_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int NUM_VC    = DEF_NUM_VC,
    localparam int PW = idx_w(NUM_PORTS),
    localparam int VW = idx_w(NUM_VC)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_PORTS-1:0][NUM_VC-1:0]         i_vc_valid,
    input  logic [NUM_PORTS-1:0][NUM_VC-1:0][PW-1:0] i_dst_port,
    input  logic [NUM_PORTS-2:0][NUM_VC-1:0]         i_credit_inc,
    input  logic [NUM_PORTS-1:0]                     i_dec_valid,
    input  logic [NUM_PORTS-1:0][VW-1:0]             i_dec_vc,
    output logic [NUM_PORTS-1:0][NUM_VC-1:0]         o_va_ok,
    output logic [NUM_PORTS-1:0][NUM_VC-1:0][VW-1:0] o_va_vc
);

    logic [NUM_PORTS-1:0][NUM_VC-1:0] credits;
    logic [NUM_PORTS-1:0][NUM_VC-1:0] allocated_op_vcs;
    logic [NUM_PORTS-1:0][NUM_VC-1:0] w_inc;
    logic [NUM_PORTS-1:0][NUM_VC-1:0] w_dec;
    logic                             w_found;
    logic [PW-1:0]                    w_d;

    // Local port never receives credit returns, so its row stays full.
    assign w_inc = {i_credit_inc, {NUM_VC{1'b0}}};

    always_comb begin
        w_dec = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int v = 0; v < NUM_VC; v++) begin
                w_dec[o][v] = i_dec_valid[o] &&
                              (int'(i_dec_vc[o]) == v);
            end
        end
    end

    always_comb begin
        allocated_op_vcs = '0;
        o_va_ok          = '0;
        o_va_vc          = '0;
        w_found          = 1'b0;
        w_d              = '0;
        for (int ip = 0; ip < NUM_PORTS; ip++) begin
            for (int iv = 0; iv < NUM_VC; iv++) begin
                w_found = 1'b0;
                w_d     = i_dst_port[ip][iv];
                if (i_vc_valid[ip][iv]) begin
                    for (int ov = 0; ov < NUM_VC; ov++) begin
                        if (!w_found && credits[w_d][ov] &&
                            !allocated_op_vcs[w_d][ov]) begin
                            w_found                  = 1'b1;
                            allocated_op_vcs[w_d][ov] = 1'b1;
                            o_va_ok[ip][iv]          = 1'b1;
                            o_va_vc[ip][iv]          = VW'(ov);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits <= '1;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                for (int v = 0; v < NUM_VC; v++) begin
                    if (w_inc[o][v] && !w_dec[o][v]) begin
                        credits[o][v] <= 1'b1;
                    end else if (!w_inc[o][v] && w_dec[o][v] &&
                                 (o != 0)) begin
                        credits[o][v] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/router_top.sv
// Single-flit VC router: input VC buffers, route compute, VC allocation,
// separable round-robin switch allocation and registered outputs.
module router_top
    import router_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int NUM_VC    = DEF_NUM_VC
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_PORTS-1:0][FLIT_DATA_WIDTH-1:0] input_data,
    input  logic [NUM_PORTS-1:0]                      input_valid,
    input  logic [NUM_PORTS-2:0][NUM_VC-1:0]          dwnstr_credit_increment,
    output logic [NUM_PORTS-2:0][NUM_VC-1:0]          upstr_credit_increment,
    output logic [NUM_PORTS-1:0][FLIT_DATA_WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]                      out_valid
);

    localparam int PW = idx_w(NUM_PORTS);
    localparam int VW = idx_w(NUM_VC);

    logic [NUM_PORTS-1:0][NUM_VC-1:0]                      vc_valid;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                      vc_empty;
    logic [NUM_PORTS-1:0][NUM_VC-1:0][FLIT_DATA_WIDTH-1:0] vc_outdata;
    logic [NUM_PORTS-1:0][NUM_VC-1:0][PW-1:0]              rc_dst_port;
    logic [NUM_PORTS-1:0][VW-1:0]                          empty_vc_index;
    logic [NUM_PORTS-1:0]                                  w_has_empty;
    logic [NUM_PORTS-1:0][PW-1:0]                          w_route;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                      w_va_ok;
    logic [NUM_PORTS-1:0][NUM_VC-1:0][VW-1:0]              w_va_vc;
    logic [NUM_PORTS-1:0][VW-1:0]                          br_vc_index;
    logic [NUM_PORTS-1:0]                                  br_vc_read_valid;
    logic [NUM_PORTS-1:0][PW-1:0]                          w_req_dst;
    logic [NUM_PORTS-1:0]                                  sa_allocated_ports;
    logic [NUM_PORTS-1:0][PW-1:0]                          w_out_win;
    logic [NUM_PORTS-1:0]                                  w_out_gnt;
    logic [NUM_PORTS-1:0][VW-1:0]                          w_dec_vc;
    logic [NUM_PORTS-1:0][VW-1:0]                          r_in_ptr;
    logic [NUM_PORTS-1:0][PW-1:0]                          r_out_ptr;

    assign vc_empty = ~vc_valid;

    always_comb begin
        empty_vc_index = '0;
        w_has_empty    = '0;
        w_route        = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_route[p] = input_data[p][DST_FIELD_MSB -: PW];
            if (int'(w_route[p]) >= NUM_PORTS) begin
                w_route[p] = '0;
            end
            for (int v = NUM_VC - 1; v >= 0; v--) begin
                if (vc_empty[p][v]) begin
                    w_has_empty[p]    = 1'b1;
                    empty_vc_index[p] = VW'(v);
                end
            end
        end
    end

    vc_availability #(
        .NUM_PORTS (NUM_PORTS),
        .NUM_VC    (NUM_VC)
    ) vcavail (
        .clk          (clk),
        .reset        (reset),
        .i_vc_valid   (vc_valid),
        .i_dst_port   (rc_dst_port),
        .i_credit_inc (dwnstr_credit_increment),
        .i_dec_valid  (w_out_gnt),
        .i_dec_vc     (w_dec_vc),
        .o_va_ok      (w_va_ok),
        .o_va_vc      (w_va_vc)
    );

    // Input stage: round-robin among VCs that obtained an output VC.
    always_comb begin
        br_vc_index      = '0;
        br_vc_read_valid = '0;
        w_req_dst        = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (!br_vc_read_valid[p] &&
                    w_va_ok[p][(int'(r_in_ptr[p]) + k) % NUM_VC]) begin
                    br_vc_read_valid[p] = 1'b1;
                    br_vc_index[p] =
                        VW'((int'(r_in_ptr[p]) + k) % NUM_VC);
                end
            end
            w_req_dst[p] = rc_dst_port[p][br_vc_index[p]];
        end
    end

    // Output stage: round-robin among input ports requesting this port.
    always_comb begin
        w_out_win          = '0;
        w_out_gnt          = '0;
        sa_allocated_ports = '0;
        w_dec_vc           = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!w_out_gnt[o] &&
                    br_vc_read_valid[(int'(r_out_ptr[o]) + k) % NUM_PORTS] &&
                    (int'(w_req_dst[(int'(r_out_ptr[o]) + k) % NUM_PORTS])
                     == o)) begin
                    w_out_gnt[o] = 1'b1;
                    w_out_win[o] =
                        PW'((int'(r_out_ptr[o]) + k) % NUM_PORTS);
                end
            end
            if (w_out_gnt[o]) begin
                sa_allocated_ports[w_out_win[o]] = 1'b1;
                w_dec_vc[o] =
                    w_va_vc[w_out_win[o]][br_vc_index[w_out_win[o]]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc_valid    <= '0;
            vc_outdata  <= '0;
            rc_dst_port <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sa_allocated_ports[p]) begin
                    vc_valid[p][br_vc_index[p]] <= 1'b0;
                end
                if (input_valid[p] && w_has_empty[p]) begin
                    vc_valid[p][empty_vc_index[p]]    <= 1'b1;
                    vc_outdata[p][empty_vc_index[p]]  <= input_data[p];
                    rc_dst_port[p][empty_vc_index[p]] <= w_route[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid              <= '0;
            out_data               <= '0;
            upstr_credit_increment <= '0;
            r_in_ptr               <= '0;
            r_out_ptr              <= '0;
        end else begin
            out_valid              <= w_out_gnt;
            upstr_credit_increment <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_out_gnt[o]) begin
                    out_data[o] <=
                        vc_outdata[w_out_win[o]][br_vc_index[w_out_win[o]]];
                    r_out_ptr[o] <=
                        PW'((int'(w_out_win[o]) + 1) % NUM_PORTS);
                end
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sa_allocated_ports[p]) begin
                    r_in_ptr[p] <=
                        VW'((int'(br_vc_index[p]) + 1) % NUM_VC);
                end
            end
            for (int p = 1; p < NUM_PORTS; p++) begin
                if (sa_allocated_ports[p]) begin
                    upstr_credit_increment[p-1][br_vc_index[p]] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_top.sv
// Bench for router_top: vector table, multi-cycle corner sequences and
// a randomized run scored against a flit-level model.
module tb_router_top;
    import router_pkg::*;

    localparam int NP = 5;
    localparam int NV = 4;
    localparam int FW = FLIT_DATA_WIDTH;
    localparam int DFW = $clog2(NP);

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NP-1:0][FW-1:0]  input_data;
    logic [NP-1:0]          input_valid;
    logic [NP-2:0][NV-1:0]  dwnstr;
    logic [NP-2:0][NV-1:0]  upstr;
    logic [NP-1:0][FW-1:0]  out_data;
    logic [NP-1:0]          out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    router_top #(.NUM_PORTS(NP), .NUM_VC(NV)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .input_data              (input_data),
        .input_valid             (input_valid),
        .dwnstr_credit_increment (dwnstr),
        .upstr_credit_increment  (upstr),
        .out_data                (out_data),
        .out_valid               (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         src;
        logic [2:0] fld;
        int         exp;
    } vec_t;

    vec_t tbl[10];

    function automatic int ref_dst(input logic [FW-1:0] f);
        int d;
        d = int'(f[FW-1 -: DFW]);
        return (d >= NP) ? 0 : d;
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act,
                         input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        input_valid = '0;
        input_data  = '0;
        dwnstr      = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Scoreboard state for the randomized run
    int          exp_dst[logic [FW-1:0]];
    int          occ[NP];
    int          deliv[NP];
    int          upc[NP];
    int          sent;
    int          seq;

    task automatic monitor();
        logic [FW-1:0] f;
        int            s;
        for (int o = 0; o < NP; o++) begin
            if (out_valid[o]) begin
                f = out_data[o];
                s = int'(f[2:0]);
                n_cmp++;
                if (!exp_dst.exists(f) || exp_dst[f] != o) begin
                    n_bad++;
                    $display("FAIL rand_route: flit %h on port %0d, want port %0d",
                             f, o, ref_dst(f));
                end else begin
                    exp_dst.delete(f);
                    occ[s]--;
                    deliv[s]++;
                end
            end
        end
        for (int p = 1; p < NP; p++) begin
            for (int v = 0; v < NV; v++) begin
                if (upstr[p-1][v]) upc[p]++;
            end
        end
    endtask

    logic [FW-1:0] d, d1, d2, f;
    logic [15:0]   eu;
    int            cnt, act_cnt;
    logic [FW-1:0] got_q[$];
    int            got_c[$];
    logic [FW-1:0] sent_q[$];

    initial begin
        tbl[0] = '{1, 3'd3, 3};
        tbl[1] = '{0, 3'd1, 1};
        tbl[2] = '{2, 3'd0, 0};
        tbl[3] = '{4, 3'd2, 2};
        tbl[4] = '{3, 3'd5, 0};
        tbl[5] = '{1, 3'd7, 0};
        tbl[6] = '{0, 3'd4, 4};
        tbl[7] = '{2, 3'd6, 0};
        tbl[8] = '{3, 3'd3, 3};
        tbl[9] = '{4, 3'd1, 1};

        // Reset state
        idle();
        reset = 1'b0;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_upstr", 32'(upstr), 32'd0);
        check("rst_out_data", 32'(|out_data), 32'd0);
        check("rst_credits", 32'(dut.vcavail.credits), 32'hFFFFF);
        reset = 1'b1;
        tick();

        // Isolated single flits: 2-cycle latency, one-cycle pulses, hold
        for (int i = 0; i < 10; i++) begin
            d = {tbl[i].fld, 29'($urandom)};
            input_data[tbl[i].src]  = d;
            input_valid[tbl[i].src] = 1'b1;
            tick();
            idle();
            check($sformatf("vec%0d_early", i), 32'(out_valid), 32'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(out_valid),
                  32'(1) << tbl[i].exp);
            check($sformatf("vec%0d_data", i), out_data[tbl[i].exp], d);
            eu = '0;
            if (tbl[i].src > 0) eu[(tbl[i].src - 1) * NV] = 1'b1;
            check($sformatf("vec%0d_upstr", i), 32'(upstr), 32'(eu));
            tick();
            check($sformatf("vec%0d_vlow", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d_hold", i), out_data[tbl[i].exp], d);
            check($sformatf("vec%0d_uplow", i), 32'(upstr), 32'd0);
        end

        // Ports 1 and 2 contend for port 4
        do_reset();
        d1 = {3'd4, 29'($urandom)};
        d2 = {3'd4, 29'($urandom)};
        input_data[1] = d1; input_valid[1] = 1'b1;
        input_data[2] = d2; input_valid[2] = 1'b1;
        tick();
        idle();
        tick();
        check("cont_v1", 32'(out_valid), 32'h10);
        check("cont_d1", out_data[4], d1);
        check("cont_up1", 32'(upstr), 32'h1);
        tick();
        check("cont_v2", 32'(out_valid), 32'h10);
        check("cont_d2", out_data[4], d2);
        check("cont_up2", 32'(upstr), 32'(1) << NV);

        // Credit exhaustion on port 2 and single-VC credit return
        do_reset();
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            idle();
            if (c == 0 || c == 2) begin
                input_data[1] = {3'd2, 29'($urandom)}; input_valid[1] = 1'b1;
                input_data[3] = {3'd2, 29'($urandom)}; input_valid[3] = 1'b1;
            end else if (c == 1) begin
                input_data[0] = {3'd2, 29'($urandom)}; input_valid[0] = 1'b1;
                input_data[4] = {3'd2, 29'($urandom)}; input_valid[4] = 1'b1;
            end
            tick();
            if (out_valid[2]) cnt++;
        end
        idle();
        check("cred_stall_cnt", cnt, 4);
        check("cred_p2_empty", 32'(dut.vcavail.credits[2]), 32'd0);
        dwnstr[1][2] = 1'b1;
        tick();
        idle();
        check("cred_vc2_back", 32'(dut.vcavail.credits[2]), 32'h4);
        check("cred_wait_valid", 32'(out_valid[2]), 32'd0);
        tick();
        check("cred_vc2_out", 32'(out_valid), 32'h4);
        check("cred_vc2_used", 32'(dut.vcavail.credits[2]), 32'd0);
        tick();
        check("cred_one_only", 32'(out_valid), 32'd0);
        dwnstr[1][0] = 1'b1;
        tick();
        idle();
        tick();
        check("cred_vc0_out", 32'(out_valid), 32'h4);
        check("cred_vc0_used", 32'(dut.vcavail.credits[2]), 32'd0);

        // Five back-to-back flits to the local port
        do_reset();
        got_q.delete(); got_c.delete(); sent_q.delete();
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 5) begin
                d = {3'd0, 29'($urandom)};
                sent_q.push_back(d);
                input_data[1] = d;
                input_valid[1] = 1'b1;
            end
            tick();
            if (out_valid[0]) begin
                got_q.push_back(out_data[0]);
                got_c.push_back(c);
            end
        end
        idle();
        check("local_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check($sformatf("local_data%0d", i), got_q[i], sent_q[i]);
            check($sformatf("local_cycle%0d", i), got_c[i], i + 1);
        end

        // Reset asserted while traffic is in flight
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < NP; p++) begin
                input_data[p]  = $urandom;
                input_valid[p] = 1'b1;
            end
            tick();
        end
        idle();
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(|out_data), 32'd0);
        check("mid_rst_upstr", 32'(upstr), 32'd0);
        check("mid_rst_vcs", 32'(dut.vc_valid), 32'd0);
        check("mid_rst_cred", 32'(dut.vcavail.credits), 32'hFFFFF);
        tick();
        reset = 1'b1;
        act_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid != '0 || upstr != '0) act_cnt++;
        end
        check("post_rst_quiet", act_cnt, 0);

        // Randomized traffic against the flit scoreboard
        do_reset();
        for (int p = 0; p < NP; p++) begin
            occ[p] = 0; deliv[p] = 0; upc[p] = 0;
        end
        sent = 0;
        seq  = 0;
        for (int c = 0; c < 600; c++) begin
            idle();
            for (int p = 0; p < NP; p++) begin
                if (occ[p] < NV && $urandom_range(0, 1) == 1) begin
                    f = {3'($urandom_range(0, 7)), 16'(seq),
                         10'($urandom), 3'(p)};
                    seq++;
                    input_data[p]  = f;
                    input_valid[p] = 1'b1;
                    exp_dst[f]     = ref_dst(f);
                    occ[p]++;
                    sent++;
                end
            end
            if ($urandom_range(0, 2) == 0) dwnstr = 16'($urandom);
            tick();
            monitor();
        end
        for (int c = 0; c < 400 && exp_dst.num() > 0; c++) begin
            idle();
            dwnstr = '1;
            tick();
            monitor();
        end
        idle();
        check("rand_undelivered", exp_dst.num(), 0);
        cnt = 0;
        for (int p = 0; p < NP; p++) cnt += deliv[p];
        check("rand_total", cnt, sent);
        for (int p = 1; p < NP; p++) begin
            check($sformatf("rand_upstr_p%0d", p), upc[p], deliv[p]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
